// File: rtl/mem_bus_responder_if.sv
// ----------------------------------------------------------------------------
// mem_bus_responder_if
//   Bus bundle between the CPU memory controller / host UART side and the
//   memory-side responder.
//
//   CPU bus  : rdy_in, mem_a[31:0], mem_wr, mem_dout[7:0] (to responder)
//              mem_din[7:0], io_buffer_full, program_done, io_overflow
//              (from responder)
//   UART TX  : uart_tx_valid, uart_tx_data[7:0] (from responder),
//              uart_tx_ready (to responder)
//   UART RX  : uart_rx_valid, uart_rx_data[7:0] (to responder)
//
//   Modports: master = CPU/host side, slave = responder side.
// ----------------------------------------------------------------------------
interface mem_bus_responder_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        program_done;
    logic        io_overflow;

    modport master (
        output rdy_in, mem_a, mem_wr, mem_dout,
        output uart_tx_ready, uart_rx_valid, uart_rx_data,
        input  mem_din, io_buffer_full, uart_tx_valid, uart_tx_data,
        input  program_done, io_overflow
    );

    modport slave (
        input  rdy_in, mem_a, mem_wr, mem_dout,
        input  uart_tx_ready, uart_rx_valid, uart_rx_data,
        output mem_din, io_buffer_full, uart_tx_valid, uart_tx_data,
        output program_done, io_overflow
    );
endinterface

// File: rtl/mem_bus_responder.sv
// ----------------------------------------------------------------------------
// mem_bus_responder
//   Memory-side responder for the CPU byte-wide memory bus: byte RAM plus a
//   memory-mapped UART TX queue (0x30000 write), RX holding register
//   (0x30000 read) and a halt register (0x30004 write). Addresses with
//   mem_a[17:16]==2'b11 are IO space, everything else is RAM.
//
//   Ports:
//     clk_in  - system clock
//     rst_in  - synchronous active-high reset
//     bus     - mem_bus_responder_if.slave (CPU bus, UART TX/RX, status)
//
//   Parameters:
//     ADDR_WIDTH      - RAM holds 2**ADDR_WIDTH bytes
//     TX_DEPTH        - TX FIFO entries (power of two, >= 4)
//     TX_DRAIN_CYCLES - minimum cycles between successive TX offers
// ----------------------------------------------------------------------------
module mem_bus_responder #(
    parameter int unsigned ADDR_WIDTH      = 17,
    parameter int unsigned TX_DEPTH        = 8,
    parameter int unsigned TX_DRAIN_CYCLES = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    mem_bus_responder_if.slave bus
);

    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned GW = (TX_DRAIN_CYCLES > 1) ? $clog2(TX_DRAIN_CYCLES) : 1;

    localparam logic [31:0]   TX_ADDR   = 32'h0003_0000;
    localparam logic [31:0]   HALT_ADDR = 32'h0003_0004;
    localparam logic [CW-1:0] DEPTH_C   = CW'(TX_DEPTH);
    localparam logic [CW-1:0] NEAR_FULL = CW'(TX_DEPTH - 2);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(TX_DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_OFFER,
        TX_GAP
    } tx_state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic is_io, bus_rd, bus_wr, ram_wr, enq_req, rx_take, halt_wr;

    always_comb begin
        is_io   = (bus.mem_a[17:16] == 2'b11);
        bus_rd  = bus.rdy_in && !bus.mem_wr;
        bus_wr  = bus.rdy_in &&  bus.mem_wr;
        ram_wr  = bus_wr && !is_io;
        enq_req = bus_wr && (bus.mem_a == TX_ADDR);
        halt_wr = bus_wr && (bus.mem_a == HALT_ADDR);
        rx_take = bus_rd && (bus.mem_a == TX_ADDR);
    end

    // ------------------------------------------------------------------
    // RAM (contents not reset)
    // ------------------------------------------------------------------
    logic [7:0] ram [2**ADDR_WIDTH];

    always_ff @(posedge clk_in) begin
        if (ram_wr) begin
            ram[bus.mem_a[ADDR_WIDTH-1:0]] <= bus.mem_dout;
        end
    end

    // ------------------------------------------------------------------
    // RX holding register
    // ------------------------------------------------------------------
    logic       rx_full_q, rx_full_d;
    logic [7:0] rx_data_q, rx_data_d;

    always_comb begin
        rx_full_d = rx_full_q;
        rx_data_d = rx_data_q;
        if (rx_full_q) begin
            if (rx_take) begin
                rx_full_d = 1'b0;
            end
        end else if (bus.uart_rx_valid) begin
            rx_full_d = 1'b1;
            rx_data_d = bus.uart_rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Read data register
    // ------------------------------------------------------------------
    logic [7:0] mem_din_q;
    logic [7:0] io_rd_data;

    always_comb begin
        io_rd_data = '0;
        if (bus.mem_a == TX_ADDR && rx_full_q) begin
            io_rd_data = rx_data_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din_q <= '0;
        end else if (bus_rd) begin
            mem_din_q <= is_io ? io_rd_data : ram[bus.mem_a[ADDR_WIDTH-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO and drain state machine
    // ------------------------------------------------------------------
    logic [7:0]    fifo_q [TX_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q, gap_d;
    tx_state_e     state_q, state_d;
    logic          tx_valid, pop, enq, fifo_full, ovf_set;

    // IDLE offers the head byte in the same cycle it finds the FIFO
    // non-empty, so a byte enqueued at one edge is visible the next cycle
    // and a GAP of TX_DRAIN_CYCLES-1 cycles spaces offers TX_DRAIN_CYCLES
    // apart. OFFER is the "still waiting for ready" state.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        tx_valid = 1'b0;
        pop      = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (count_q != '0 && gap_q == '0) begin
                    tx_valid = 1'b1;
                    if (bus.uart_tx_ready) begin
                        pop     = 1'b1;
                        gap_d   = GAP_LOAD;
                        state_d = (GAP_LOAD == '0) ? TX_IDLE : TX_GAP;
                    end else begin
                        state_d = TX_OFFER;
                    end
                end
            end
            TX_OFFER: begin
                tx_valid = 1'b1;
                if (bus.uart_tx_ready) begin
                    pop     = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = (GAP_LOAD == '0) ? TX_IDLE : TX_GAP;
                end
            end
            TX_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end
                if (gap_q <= GW'(1)) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_full = (count_q == DEPTH_C);
        enq       = enq_req && (!fifo_full || pop);
        ovf_set   = enq_req && fifo_full && !pop;
        wptr_d    = enq ? wptr_q + PW'(1) : wptr_q;
        rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
        count_d   = count_q;
        if (enq && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !enq) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq) begin
            fifo_q[wptr_q] <= bus.mem_dout;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic buf_full_q, done_q, ovf_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= TX_IDLE;
            gap_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rx_full_q  <= 1'b0;
            rx_data_q  <= '0;
            buf_full_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rx_full_q  <= rx_full_d;
            rx_data_q  <= rx_data_d;
            // Lags the count by one cycle; the threshold leaves two
            // entries of slack for a late-sampling controller.
            buf_full_q <= (count_q >= NEAR_FULL);
            done_q     <= done_q | halt_wr;
            ovf_q      <= ovf_q | ovf_set;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_din        = mem_din_q;
        bus.io_buffer_full = buf_full_q;
        bus.uart_tx_valid  = tx_valid;
        bus.uart_tx_data   = tx_valid ? fifo_q[rptr_q] : '0;
        bus.program_done   = done_q;
        bus.io_overflow    = ovf_q;
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_responder
//   Directed stimulus with a scoreboard: expected read data and expected TX
//   bytes are queued when stimulus is issued; a negedge monitor pops and
//   compares when a read result or a TX handshake appears.
// ----------------------------------------------------------------------------
module tb_mem_bus_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_responder_if bus ();

    mem_bus_responder #(
        .ADDR_WIDTH      (17),
        .TX_DEPTH        (8),
        .TX_DRAIN_CYCLES (4)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_q [$];
    logic [7:0] tx_q [$];
    int         offer_starts [$];
    int         cyc = 0;
    logic       rd_pend = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] mon_exp;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        cyc++;
        if (rd_pend && !rst) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_extra: got %02h, no read expected", bus.mem_din);
            end else begin
                mon_exp = rd_q.pop_front();
                if (bus.mem_din !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data: got %02h expected %02h", bus.mem_din, mon_exp);
                end
            end
        end
        rd_pend = !rst && bus.rdy_in && !bus.mem_wr;

        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.uart_tx_valid && !prev_valid) offer_starts.push_back(cyc);
            if (bus.uart_tx_valid && bus.uart_tx_ready) begin
                checks++;
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_extra: got %02h, no byte expected", bus.uart_tx_data);
                end else begin
                    mon_exp = tx_q.pop_front();
                    if (bus.uart_tx_data !== mon_exp) begin
                        errors++;
                        $display("FAIL tx_data: got %02h expected %02h", bus.uart_tx_data, mon_exp);
                    end
                end
            end
            prev_valid = bus.uart_tx_valid;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rdy_in = 1'b0;
        bus.mem_wr = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus.rdy_in   = 1'b1;
        bus.mem_wr   = 1'b1;
        bus.mem_a    = a;
        bus.mem_dout = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        bus.rdy_in = 1'b1;
        bus.mem_wr = 1'b0;
        bus.mem_a  = a;
        tick();
        idle();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_din"},  {24'h0, bus.mem_din}, 32'h0);
        chk({tag, "_buf_full"}, {31'h0, bus.io_buffer_full}, 32'h0);
        chk({tag, "_tx_valid"}, {31'h0, bus.uart_tx_valid}, 32'h0);
        chk({tag, "_tx_data"},  {24'h0, bus.uart_tx_data}, 32'h0);
        chk({tag, "_done"},     {31'h0, bus.program_done}, 32'h0);
        chk({tag, "_overflow"}, {31'h0, bus.io_overflow}, 32'h0);
    endtask

    task automatic drain_wait(input string name, input int budget);
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, tx_q.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.rdy_in        = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.mem_a         = '0;
        bus.mem_dout      = '0;
        bus.uart_tx_ready = 1'b1;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = '0;

        rst = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // RAM write/read, back-to-back reads, unmapped IO
        wr(32'h0000_0100, 8'hA5);
        rd(32'h0000_0100, 8'hA5);
        wr(32'h0000_0101, 8'h3C);
        rd(32'h0000_0101, 8'h3C);
        rd(32'h0000_0100, 8'hA5);
        rd(32'h0000_0101, 8'h3C);
        wr(32'h0003_0008, 8'h77);
        rd(32'h0003_0008, 8'h00);

        // rdy_in low blocks the write
        wr(32'h0000_0200, 8'h11);
        bus.rdy_in   = 1'b0;
        bus.mem_wr   = 1'b1;
        bus.mem_a    = 32'h0000_0200;
        bus.mem_dout = 8'hFF;
        tick();
        idle();
        rd(32'h0000_0200, 8'h11);

        // RX holding register: second byte ignored while full
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h5A;
        tick();
        bus.uart_rx_data  = 8'h77;
        tick();
        bus.uart_rx_valid = 1'b0;
        rd(32'h0003_0000, 8'h5A);
        rd(32'h0003_0000, 8'h00);

        // TX path with ready tied high: offers 4 cycles apart
        bus.uart_tx_ready = 1'b1;
        offer_starts.delete();
        tx_q.push_back(8'h48);
        tx_q.push_back(8'h69);
        wr(32'h0003_0000, 8'h48);
        wr(32'h0003_0000, 8'h69);
        drain_wait("tx_drain2", 40);
        chk("tx_offer_count", offer_starts.size(), 2);
        if (offer_starts.size() >= 2)
            chk("tx_offer_spacing", offer_starts[1] - offer_starts[0], 4);
        repeat (8) tick();

        // Flow control: fill with ready low, overflow on ninth write
        bus.uart_tx_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) tx_q.push_back(8'(8'h10 + k));
            bus.rdy_in   = 1'b1;
            bus.mem_wr   = 1'b1;
            bus.mem_a    = 32'h0003_0000;
            bus.mem_dout = 8'(8'h10 + k);
            // count is k-1 now; the flag reflects the previous cycle's count
            chk($sformatf("buf_full_k%0d", k), {31'h0, bus.io_buffer_full}, (k >= 8) ? 32'h1 : 32'h0);
            if (k == 9) chk("overflow_before", {31'h0, bus.io_overflow}, 32'h0);
            tick();
        end
        idle();
        chk("overflow_set", {31'h0, bus.io_overflow}, 32'h1);
        chk("stall_head", {24'h0, bus.uart_tx_data}, 32'h11);
        bus.uart_tx_ready = 1'b1;
        drain_wait("tx_drain8", 100);
        repeat (10) tick();
        chk("tx_no_ninth", {31'h0, bus.uart_tx_valid}, 32'h0);
        chk("buf_full_clear", {31'h0, bus.io_buffer_full}, 32'h0);
        chk("overflow_sticky", {31'h0, bus.io_overflow}, 32'h1);

        // Halt flag is sticky and bus keeps working
        wr(32'h0003_0004, 8'h00);
        chk("done_set", {31'h0, bus.program_done}, 32'h1);
        rd(32'h0000_0100, 8'hA5);
        tick();
        chk("done_sticky", {31'h0, bus.program_done}, 32'h1);

        // Reset mid-offer
        bus.uart_tx_ready = 1'b0;
        wr(32'h0003_0000, 8'hEE);
        chk("offer_active", {31'h0, bus.uart_tx_valid}, 32'h1);
        chk("offer_data", {24'h0, bus.uart_tx_data}, 32'hEE);
        rst = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        bus.uart_tx_ready = 1'b1;
        repeat (4) tick();
        chk("fifo_flushed", {31'h0, bus.uart_tx_valid}, 32'h0);
        rd(32'h0000_0101, 8'h3C);

        repeat (3) tick();
        chk("sb_empty", rd_q.size() + tx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
